osc_freq_monitor: RTL and testbench
===================================

// Module: osc_freq_monitor
// PURPOSE
//   Consumer-side checker for a fabric oscillator output (RC or XTL clock routed to fabric).
//   Counts rising edges of an asynchronous measured clock over a fixed gate window timed by
//   the system clock, then reports the count and in-range / out-of-range / dead-clock flags.
//   Sits beside the oscillator wrapper; flags feed the status register / fault logic.
// PARAMETERS
//   GATE_CYCLES  50000     gate window length in clk cycles (>=2)
//   CNT_WIDTH    24        width of edge counter and count_out
//   EXPECT_MIN   900       lowest count (inclusive) considered in range
//   EXPECT_MAX   1100      highest count (inclusive) considered in range
// PORTS
//   clk          in   1          system clock; times the gate window
//   rst          in   1          synchronous reset, active-high
//   meas_in      in   1          measured clock, asynchronous to clk
//   start        in   1          1-cycle request to begin a measurement
//   continuous   in   1          1 = re-arm automatically after each result
//   busy         out  1          high while a gate window is open
//   count_valid  out  1          1-cycle pulse: new result on count_out/flags
//   count_out    out  CNT_WIDTH  rising edges counted in last window (held)
//   freq_ok      out  1          EXPECT_MIN <= count_out <= EXPECT_MAX
//   freq_low     out  1          count_out < EXPECT_MIN
//   freq_high    out  1          count_out > EXPECT_MAX (incl. saturation)
//   no_clock     out  1          count_out == 0
// BEHAVIOUR
//   Clock / reset: everything on rising clk; rst synchronous, active-high, overrides all.
//   Reset values: busy=0, count_valid=0, count_out=0, freq_ok/low/high=0, no_clock=0,
//     state=IDLE, synchroniser flops=0, gate and edge counters=0.
//   Input path: meas_in -> 2-flop synchroniser -> 3rd flop; edge = s2 & ~s3.
//     Edge detect lags meas_in by 2-3 clk. meas_in high and low phases must each exceed
//     1.5 clk periods (f_meas < f_clk/3); faster inputs undercount, not a fault.
//   States:
//     IDLE: busy=0. start=1 -> GATE; clear gate_cnt and edge_cnt.
//     GATE: busy=1. gate_cnt increments every cycle; edge_cnt += edge (saturating at
//       all-ones, never wraps). Window covers exactly GATE_CYCLES cycles; the edge
//       sampled on the cycle gate_cnt==GATE_CYCLES-1 is included. Then -> DONE.
//     DONE: 1 cycle. count_out<=edge_cnt, flags updated from edge_cnt, count_valid=1,
//       busy=0. Next: continuous=1 -> GATE (counters cleared; one-cycle gap, edges in
//       DONE cycle not counted); else -> IDLE.
//   Latency: start at cycle N -> count_valid high at cycle N+1+GATE_CYCLES.
//   Flags: exactly one of freq_ok/freq_low/freq_high set after first result; no_clock
//     additionally set (with freq_low) when count is 0. Flags and count_out hold
//     until next DONE.
//   Saturation: edge_cnt at 2^CNT_WIDTH-1 stays there; reported as freq_high.
//   start while busy or in DONE: ignored. continuous dropped during GATE: current window
//     completes, then IDLE. start and continuous may be asserted together.
//   rst mid-window: window aborted, no count_valid, outputs return to reset values.
//   Synchroniser stages are excluded from the reset requirement only for timing
//     constraint tagging; they are still reset.
// TESTING (bench uses GATE_CYCLES=1000, EXPECT_MIN=90, EXPECT_MAX=110, CNT_WIDTH=12)
//   1. meas_in period 10 clk, start pulse -> count_valid exactly 1001 cycles later,
//      count_out=100 (+/-1), freq_ok=1, busy high for 1000 cycles.
//   2. meas_in held 0, start -> count_out=0, no_clock=1, freq_low=1, freq_ok=0.
//   3. meas_in period 4 clk, start -> count_out=250, freq_high=1; then CNT_WIDTH=7 build
//      -> count_out=127 (saturated), freq_high=1.
//   4. continuous=1, period 10 then switch to period 12 mid-run -> pulses every 1001
//      cycles; results 100 then 83 (freq_low=1) after the switch window.
//   5. start at cycle 0, rst at cycle 500 -> no count_valid, all outputs 0; start again
//      -> normal result 1001 cycles later.
//   6. extra start pulses during GATE -> ignored, single count_valid, count unchanged.

Source files
------------

// File: rtl/osc_freq_monitor.sv
// Counts rising edges of an asynchronous measured clock over a fixed clk-timed gate
// window and classifies the count against an expected range.
//
// state | meaning
// IDLE  | waiting for start
// GATE  | window open, counting synchronised meas_in edges
// DONE  | one cycle: result presented with count_valid
module osc_freq_monitor #(
  parameter int unsigned GATE_CYCLES = 50000,
  parameter int unsigned CNT_WIDTH   = 24,
  parameter int unsigned EXPECT_MIN  = 900,
  parameter int unsigned EXPECT_MAX  = 1100
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 meas_in,
  input  logic                 start,
  input  logic                 continuous,
  output logic                 busy,
  output logic                 count_valid,
  output logic [CNT_WIDTH-1:0] count_out,
  output logic                 freq_ok,
  output logic                 freq_low,
  output logic                 freq_high,
  output logic                 no_clock
);

  localparam int unsigned GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GATE = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic meas_s1, meas_s2, meas_s3;
  logic meas_edge;

  logic [GW-1:0]        gate_cnt;
  logic [CNT_WIDTH-1:0] edge_cnt;
  logic [CNT_WIDTH-1:0] edge_cnt_inc;
  logic [31:0]          result_ext;
  logic                 gate_last;
  logic                 clear_cnt;
  logic                 result_load;

  // meas_s1/meas_s2 form the synchroniser; meas_s3 only serves the edge detector.
  always_ff @(posedge clk) begin
    if (rst) begin
      meas_s1 <= 1'b0;
      meas_s2 <= 1'b0;
      meas_s3 <= 1'b0;
    end else begin
      meas_s1 <= meas_in;
      meas_s2 <= meas_s1;
      meas_s3 <= meas_s2;
    end
  end

  assign meas_edge = meas_s2 & ~meas_s3;

  assign gate_last    = (gate_cnt == GATE_LAST);
  assign edge_cnt_inc = (meas_edge && (edge_cnt != CNT_MAX)) ? edge_cnt + CNT_WIDTH'(1)
                                                              : edge_cnt;
  assign result_ext   = 32'(edge_cnt_inc);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    clear_cnt   = 1'b0;
    result_load = 1'b0;
    busy        = 1'b0;
    count_valid = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = GATE;
          clear_cnt  = 1'b1;
        end
      end
      GATE: begin
        busy = 1'b1;
        if (gate_last) begin
          state_next  = DONE;
          result_load = 1'b1;
        end
      end
      DONE: begin
        count_valid = 1'b1;
        if (continuous) begin
          state_next = GATE;
          clear_cnt  = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gate_cnt <= '0;
      edge_cnt <= '0;
    end else if (clear_cnt) begin
      gate_cnt <= '0;
      edge_cnt <= '0;
    end else if (state == GATE) begin
      if (!gate_last) begin
        gate_cnt <= gate_cnt + GW'(1);
      end
      edge_cnt <= edge_cnt_inc;
    end
  end

  // The result is captured on the last gate cycle, including that cycle's edge, so it
  // is already stable on the outputs while count_valid is high in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_out <= '0;
      freq_ok   <= 1'b0;
      freq_low  <= 1'b0;
      freq_high <= 1'b0;
      no_clock  <= 1'b0;
    end else if (result_load) begin
      count_out <= edge_cnt_inc;
      freq_low  <= (result_ext < EXPECT_MIN);
      freq_high <= (result_ext > EXPECT_MAX);
      freq_ok   <= (result_ext >= EXPECT_MIN) && (result_ext <= EXPECT_MAX);
      no_clock  <= (edge_cnt_inc == '0);
    end
  end

endmodule

// File: tb/tb_osc_freq_monitor.sv
// Directed bench for osc_freq_monitor: scoreboard of expected results, checked when
// count_valid pulses; a second narrow-counter instance covers saturation.
`timescale 1ns/1ps
module tb_osc_freq_monitor;

  localparam int G  = 1000;
  localparam int W  = 12;
  localparam int WS = 7;

  logic clk, rst, meas_in, start, start_sat, continuous;
  logic busy, count_valid, freq_ok, freq_low, freq_high, no_clock;
  logic [W-1:0] count_out;
  logic busy_s, valid_s, ok_s, low_s, high_s, noclk_s;
  logic [WS-1:0] count_s;

  typedef struct {
    int lo;
    int hi;
    bit flags;
    bit ok;
    bit low;
    bit high;
    bit noclk;
  } exp_t;

  exp_t sb[$];
  exp_t sb_sat[$];
  exp_t e_main, e_sat;

  int checks = 0;
  int passed = 0;
  int cyc    = 0;
  int t0     = 0;
  int half   = 0;
  int lat, nb;

  osc_freq_monitor #(.GATE_CYCLES(G), .CNT_WIDTH(W), .EXPECT_MIN(90), .EXPECT_MAX(110)) dut (
    .clk(clk), .rst(rst), .meas_in(meas_in), .start(start), .continuous(continuous),
    .busy(busy), .count_valid(count_valid), .count_out(count_out), .freq_ok(freq_ok),
    .freq_low(freq_low), .freq_high(freq_high), .no_clock(no_clock)
  );

  osc_freq_monitor #(.GATE_CYCLES(G), .CNT_WIDTH(WS), .EXPECT_MIN(90), .EXPECT_MAX(110)) dut_sat (
    .clk(clk), .rst(rst), .meas_in(meas_in), .start(start_sat), .continuous(continuous),
    .busy(busy_s), .count_valid(valid_s), .count_out(count_s), .freq_ok(ok_s),
    .freq_low(low_s), .freq_high(high_s), .no_clock(noclk_s)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Measured clock: transitions 2 ns before a clk rising edge, half period = half clk cycles.
  initial begin
    meas_in = 1'b0;
    #3;
    forever begin
      if (half == 0) begin
        meas_in = 1'b0;
        #10;
      end else begin
        #(half * 10);
        meas_in = ~meas_in;
      end
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
    checks++;
    assert (obs >= lo && obs <= hi) passed++;
    else $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
  endtask

  task automatic push_exp(input bit sat, input int lo, input int hi, input bit flags,
                          input bit ok, input bit low, input bit high, input bit nc);
    exp_t e;
    e.lo = lo; e.hi = hi; e.flags = flags;
    e.ok = ok; e.low = low; e.high = high; e.noclk = nc;
    if (sat) sb_sat.push_back(e);
    else sb.push_back(e);
  endtask

  task automatic compare(input string tag, input exp_t e, input int cnt, input logic ok,
                         input logic low, input logic high, input logic nc);
    chk_rng({tag, "_count"}, cnt, e.lo, e.hi);
    if (e.flags) begin
      chk({tag, "_freq_ok"}, int'(ok), int'(e.ok));
      chk({tag, "_freq_low"}, int'(low), int'(e.low));
      chk({tag, "_freq_high"}, int'(high), int'(e.high));
      chk({tag, "_no_clock"}, int'(nc), int'(e.noclk));
    end
    chk({tag, "_one_flag"}, int'(ok) + int'(low) + int'(high), 1);
  endtask

  always @(negedge clk) begin
    if (!rst && count_valid) begin
      chk("main_valid_expected", int'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e_main = sb.pop_front();
        compare("main", e_main, int'(count_out), freq_ok, freq_low, freq_high, no_clock);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && valid_s) begin
      chk("sat_valid_expected", int'(sb_sat.size() != 0), 1);
      if (sb_sat.size() != 0) begin
        e_sat = sb_sat.pop_front();
        compare("sat", e_sat, int'(count_s), ok_s, low_s, high_s, noclk_s);
      end
    end
  end

  task automatic do_start(input bit sat);
    @(negedge clk);
    start = 1'b1;
    start_sat = sat;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    start_sat = 1'b0;
  endtask

  task automatic wait_valid(input int bound, output int l, output int nbusy);
    l = -1;
    nbusy = 0;
    for (int i = 0; i < bound; i++) begin
      if (count_valid) begin
        l = cyc - t0;
        t0 = cyc;
        break;
      end
      if (busy) nbusy++;
      @(negedge clk);
    end
  endtask

  task automatic quiet(input int n, input string tag);
    int v = 0;
    int b = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (count_valid) v++;
      if (busy) b++;
    end
    chk({tag, "_no_valid"}, v, 0);
    chk({tag, "_no_busy"}, b, 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_valid"}, int'(count_valid), 0);
    chk({tag, "_count"}, int'(count_out), 0);
    chk({tag, "_ok"}, int'(freq_ok), 0);
    chk({tag, "_low"}, int'(freq_low), 0);
    chk({tag, "_high"}, int'(freq_high), 0);
    chk({tag, "_noclk"}, int'(no_clock), 0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    start_sat = 1'b0;
    continuous = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    chk("reset_sat_count", int'(count_s), 0);
    rst = 1'b0;

    // 1: period 10 -> 100 edges, in range
    half = 5;
    repeat (20) @(negedge clk);
    push_exp(0, 99, 101, 1, 1, 0, 0, 0);
    do_start(0);
    wait_valid(G + 100, lat, nb);
    chk("t1_latency", lat, G + 1);
    chk("t1_busy_cycles", nb, G);

    // 2: dead clock
    half = 0;
    repeat (20) @(negedge clk);
    push_exp(0, 0, 0, 1, 0, 1, 0, 1);
    do_start(0);
    wait_valid(G + 100, lat, nb);
    chk("t2_latency", lat, G + 1);
    @(negedge clk);
    chk("t2_hold_noclk", int'(no_clock), 1);
    chk("t2_hold_low", int'(freq_low), 1);

    // 3: period 4 -> 250 edges; 7-bit instance saturates at 127
    half = 2;
    repeat (20) @(negedge clk);
    push_exp(0, 250, 250, 1, 0, 0, 1, 0);
    push_exp(1, 127, 127, 1, 0, 0, 1, 0);
    do_start(1);
    wait_valid(G + 100, lat, nb);
    chk("t3_latency", lat, G + 1);

    // 4: continuous, period 10 then 12; mixed second window only range-checked
    half = 5;
    repeat (20) @(negedge clk);
    push_exp(0, 99, 101, 1, 1, 0, 0, 0);
    push_exp(0, 82, 101, 0, 0, 0, 0, 0);
    push_exp(0, 83, 84, 1, 0, 1, 0, 0);
    push_exp(0, 83, 84, 1, 0, 1, 0, 0);
    continuous = 1'b1;
    do_start(0);
    wait_valid(G + 100, lat, nb);
    chk("t4_latency_w1", lat, G + 1);
    half = 6;
    @(negedge clk);
    wait_valid(G + 100, lat, nb);
    chk("t4_period_w2", lat, G + 1);
    @(negedge clk);
    wait_valid(G + 100, lat, nb);
    chk("t4_period_w3", lat, G + 1);
    repeat (500) @(negedge clk);
    continuous = 1'b0;
    wait_valid(G + 100, lat, nb);
    chk("t4_period_w4", lat, G + 1);
    quiet(G + 100, "t4_stop");

    // 5: reset mid-window aborts it
    half = 5;
    repeat (20) @(negedge clk);
    do_start(0);
    repeat (498) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_zero("t5_rst");
    rst = 1'b0;
    quiet(G + 100, "t5_abort");
    push_exp(0, 99, 101, 1, 1, 0, 0, 0);
    do_start(0);
    wait_valid(G + 100, lat, nb);
    chk("t5_latency", lat, G + 1);

    // 6: extra start pulses during GATE and in DONE are ignored
    push_exp(0, 99, 101, 1, 1, 0, 0, 0);
    do_start(0);
    repeat (100) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (400) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_valid(G + 100, lat, nb);
    chk("t6_latency", lat, G + 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t6_done_start_busy", int'(busy), 0);
    quiet(G + 100, "t6");

    chk("sb_empty", sb.size(), 0);
    chk("sb_sat_empty", sb_sat.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
